// File: rtl/led_pio_pkg.sv
// Shared register map and STATUS layout for the LED PWM PIO slave.
package led_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_SET      = 3'd1,
        ADDR_CLEAR    = 3'd2,
        ADDR_MODE     = 3'd3,
        ADDR_DUTY     = 3'd4,
        ADDR_DIV      = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_UNMAPPED = 3'd7
    } reg_addr_e;

    localparam int DIV_BITS           = 16;
    localparam int STATUS_CNT_LSB     = 0;
    localparam int STATUS_PENDING_BIT = 16;

    function automatic logic [31:0] status_word(input logic pending, input logic [15:0] cnt);
        logic [31:0] word;
        word = 32'(cnt) << STATUS_CNT_LSB;
        word[STATUS_PENDING_BIT] = pending;
        return word;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Prescaler, PWM period counter and double-buffered duty cycle.
module led_pwm_gen
    import led_pio_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DIV_BITS-1:0] div,
    input  logic                div_write,
    input  logic                duty_write,
    input  logic [PWM_BITS-1:0] duty_data,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty_active,
    output logic [PWM_BITS-1:0] duty_shadow,
    output logic                duty_pending
);

    logic [DIV_BITS-1:0] prescale;
    logic                tick;
    logic                wrap;

    assign tick = (prescale == div);
    assign wrap = tick && (pwm_cnt == {PWM_BITS{1'b1}});

    // A DIV write restarts the prescale interval so the new divisor starts cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (div_write || tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Active duty only changes at a period boundary; a write landing on that
    // same edge is kept pending for the following period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_shadow  <= '0;
            duty_active  <= '0;
            duty_pending <= 1'b0;
        end else begin
            if (wrap) begin
                duty_active  <= duty_shadow;
                duty_pending <= 1'b0;
            end
            if (duty_write) begin
                duty_shadow  <= duty_data;
                duty_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED output port with per-channel PWM dimming.
module led_pwm_pio
    import led_pio_pkg::*;
#(
    parameter int               WIDTH      = 6,
    parameter int               PWM_BITS   = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                write;
    reg_addr_e           reg_addr;
    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    mode;
    logic [WIDTH-1:0]    next_out;
    logic [DIV_BITS-1:0] div;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_active;
    logic [PWM_BITS-1:0] duty_shadow;
    logic                duty_pending;
    logic                pwm_on;
    logic                unused_writedata;

    assign write            = chipselect & ~write_n;
    assign reg_addr         = reg_addr_e'(address);
    assign unused_writedata = ^writedata[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_DATA;
            mode <= '0;
            div  <= '0;
        end else if (write) begin
            case (reg_addr)
                ADDR_DATA:  data <= writedata[WIDTH-1:0];
                ADDR_SET:   data <= data | writedata[WIDTH-1:0];
                ADDR_CLEAR: data <= data & ~writedata[WIDTH-1:0];
                ADDR_MODE:  mode <= writedata[WIDTH-1:0];
                ADDR_DIV:   div  <= writedata[DIV_BITS-1:0];
                default:    ;
            endcase
        end
    end

    led_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .div          (div),
        .div_write    (write && (reg_addr == ADDR_DIV)),
        .duty_write   (write && (reg_addr == ADDR_DUTY)),
        .duty_data    (writedata[PWM_BITS-1:0]),
        .pwm_cnt      (pwm_cnt),
        .duty_active  (duty_active),
        .duty_shadow  (duty_shadow),
        .duty_pending (duty_pending)
    );

    assign pwm_on = (pwm_cnt < duty_active);

    always_comb begin
        next_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_out[i] = data[i] & (mode[i] ? pwm_on : 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_DATA;
        end else begin
            out_port <= next_out;
        end
    end

    // SET and CLEAR read back DATA so software can read-modify-write through any alias.
    always_comb begin
        readdata = '0;
        case (reg_addr)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data);
            ADDR_MODE:   readdata = 32'(mode);
            ADDR_DUTY:   readdata = 32'(duty_shadow);
            ADDR_DIV:    readdata = 32'(div);
            ADDR_STATUS: readdata = status_word(duty_pending, 16'(pwm_cnt));
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Self-checking bench for led_pwm_pio: cycle model plus directed literal checks.
module tb_led_pwm_pio;

    localparam int         WIDTH    = 6;
    localparam int         PWM_BITS = 8;
    localparam int         PERIOD   = 256;
    localparam logic [5:0] RST_DATA = 6'h2A;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [5:0]  out_port;

    int checks   = 0;
    int failures = 0;

    led_pwm_pio #(
        .WIDTH      (WIDTH),
        .PWM_BITS   (PWM_BITS),
        .RESET_DATA (RST_DATA)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Behavioural model: elapsed-cycle arithmetic rather than a prescaler register.
    logic [5:0] m_data, m_mode, m_out;
    logic       m_pending;
    int         m_div, m_elapsed, m_cnt, m_shadow, m_active;
    bit         m_tick, m_wrap, m_we;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2: return {26'd0, m_data};
            3'd3:             return {26'd0, m_mode};
            3'd4:             return 32'(m_shadow);
            3'd5:             return 32'(m_div);
            3'd6:             return {15'd0, m_pending, 16'(m_cnt % PERIOD)};
            default:          return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data = RST_DATA; m_mode = '0; m_out = RST_DATA;
            m_div = 0; m_elapsed = 0; m_cnt = 0;
            m_shadow = 0; m_active = 0; m_pending = 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                m_out[i] = m_data[i] && (!m_mode[i] || ((m_cnt % PERIOD) < m_active));
            m_tick = ((m_elapsed % (m_div + 1)) == m_div);
            m_wrap = m_tick && ((m_cnt % PERIOD) == PERIOD - 1);
            if (m_wrap) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (m_tick) m_cnt++;
            m_we = chipselect && !write_n;
            if (m_we && address == 3'd5) m_elapsed = 0;
            else m_elapsed++;
            if (m_we) begin
                case (address)
                    3'd0: m_data = writedata[5:0];
                    3'd1: m_data = m_data | writedata[5:0];
                    3'd2: m_data = m_data & ~writedata[5:0];
                    3'd3: m_mode = writedata[5:0];
                    3'd4: begin m_shadow = int'(writedata[7:0]); m_pending = 1'b1; end
                    3'd5: m_div = int'(writedata[15:0]);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (out_port !== m_out) begin
            failures++;
            $display("[TB] FAIL model_out_port t=%0t actual=0x%02h required=0x%02h", $time, out_port, m_out);
        end
        checks++;
        if (readdata !== model_read(address)) begin
            failures++;
            $display("[TB] FAIL model_readdata addr=%0d t=%0t actual=0x%08h required=0x%08h",
                     address, $time, readdata, model_read(address));
        end
    end

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_at(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic edges_until_pending_clear(input int limit, output int n);
        address = 3'd6;
        n = 0;
        do begin
            step(1);
            n++;
        end while (readdata[16] === 1'b1 && n < limit);
        check_value("pending_cleared", {31'd0, readdata[16]}, 32'd0);
    endtask

    task automatic edges_until_cnt_change(input int limit, output int n);
        logic [7:0] old;
        address = 3'd6;
        #1;
        old = readdata[7:0];
        n = 0;
        do begin
            step(1);
            n++;
        end while (readdata[7:0] == old && n < limit);
    endtask

    task automatic edges_until_cnt(input logic [7:0] target, input int limit);
        int n;
        address = 3'd6;
        #1;
        n = 0;
        while (readdata[7:0] != target && n < limit) begin
            step(1);
            n++;
        end
        check_value("cnt_reached", {24'd0, readdata[7:0]}, {24'd0, target});
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (PERIOD) begin
            step(1);
            if (out_port[0] === 1'b1) hi++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int hi;

        #1 reset_n = 1'b0;
        step(3);
        check_value("reset_out_port", {26'd0, out_port}, 32'h2A);
        read_at(3'd0, rd); check_value("reset_data", rd, 32'h2A);
        read_at(3'd6, rd); check_value("reset_status", rd, 32'h0);
        read_at(3'd7, rd); check_value("unmapped_read", rd, 32'h0);
        reset_n = 1'b1;
        step(1);

        bus_write(3'd0, 32'h15);
        check_value("data_latency_old", {26'd0, out_port}, 32'h2A);
        step(1);
        check_value("data_latency_new", {26'd0, out_port}, 32'h15);
        read_at(3'd0, rd); check_value("data_read", rd, 32'h0000_0015);

        bus_write(3'd1, 32'h0A);
        read_at(3'd0, rd); check_value("set_result", rd, 32'h1F);
        bus_write(3'd2, 32'h03);
        read_at(3'd1, rd); check_value("set_alias_read", rd, 32'h1C);
        read_at(3'd2, rd); check_value("clear_alias_read", rd, 32'h1C);

        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        read_at(3'd0, rd); check_value("ignored_writes", rd, 32'h1C);

        bus_write(3'd3, 32'hFFFF_FFC1);
        read_at(3'd3, rd); check_value("mode_masked", rd, 32'h01);
        bus_write(3'd0, 32'h01);
        bus_write(3'd4, 32'hFFFF_FF40);
        read_at(3'd4, rd); check_value("duty_shadow_read", rd, 32'h40);
        read_at(3'd6, rd); check_value("duty_pending_set", {31'd0, rd[16]}, 32'd1);
        edges_until_pending_clear(600, n);
        count_high(hi);
        check_value("duty64_high_count", 32'(hi), 32'd64);

        bus_write(3'd5, 32'h3);
        edges_until_cnt_change(20, n);
        edges_until_cnt_change(20, n);
        check_value("div3_tick_period", 32'(n), 32'd4);
        edges_until_cnt_change(20, n);
        check_value("div3_tick_period_2", 32'(n), 32'd4);
        step(1);
        bus_write(3'd5, 32'h3);
        edges_until_cnt_change(20, n);
        check_value("div_rewrite_restart", 32'(n), 32'd4);
        bus_write(3'd5, 32'h0);

        bus_write(3'd4, 32'h0);
        edges_until_pending_clear(600, n);
        count_high(hi);
        check_value("duty0_high_count", 32'(hi), 32'd0);

        bus_write(3'd4, 32'hFF);
        edges_until_pending_clear(600, n);
        count_high(hi);
        check_value("duty255_high_count", 32'(hi), 32'd255);

        edges_until_cnt(8'd255, 300);
        bus_write(3'd4, 32'h20);
        read_at(3'd6, rd);
        check_value("wrap_write_pending", {31'd0, rd[16]}, 32'd1);
        check_value("wrap_cnt_zero", {24'd0, rd[7:0]}, 32'd0);
        read_at(3'd4, rd); check_value("wrap_shadow", rd, 32'h20);
        edges_until_pending_clear(600, n);
        check_value("wrap_pending_period", 32'(n), 32'd256);

        bus_write(3'd4, 32'd10);
        read_at(3'd6, rd); check_value("pre_reset_pending", {31'd0, rd[16]}, 32'd1);
        step(5);
        address = 3'd6;
        #2 reset_n = 1'b0;
        #1;
        check_value("async_reset_out_port", {26'd0, out_port}, 32'h2A);
        check_value("async_reset_status", readdata, 32'h0);
        step(1);
        read_at(3'd4, rd); check_value("reset_duty_shadow", rd, 32'h0);
        read_at(3'd3, rd); check_value("reset_mode", rd, 32'h0);
        reset_n = 1'b1;
        step(300);
        read_at(3'd6, rd); check_value("pending_lost", {31'd0, rd[16]}, 32'd0);
        check_value("post_reset_out_port", {26'd0, out_port}, 32'h2A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_pio.md
LED_PWM_PIO -- requirements
Module: led_pwm_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 6, output channel count, legal 1..32.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter/duty width, legal 2..16.
REQ-003 SHALL have parameter RESET_DATA, default 0, WIDTH-bit reset value of DATA.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, zero read latency.
REQ-011 SHALL have port out_port  output  WIDTH  registered channel outputs.

Function
REQ-012 SHALL decode write = chipselect & ~write_n; no wait states, accepted every cycle.
REQ-013 SHALL implement register map: 0 DATA rw; 1 SET wo; 2 CLEAR wo; 3 MODE rw; 4 DUTY rw; 5 DIV rw [15:0]; 6 STATUS ro.
REQ-014 SHALL on SET write do DATA <= DATA | writedata[WIDTH-1:0]; on CLEAR write do DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-015 SHALL return DATA when reading SET or CLEAR; STATUS = {15'b0, duty_pending at bit 16, pwm_cnt zero-extended}.
REQ-016 SHALL drive readdata combinationally from address, zero-extending every field; unmapped address 7 reads 0; writes to STATUS/7 ignored.
REQ-017 SHALL run a 16-bit prescaler counting 0..DIV, emitting a one-cycle tick when count == DIV, then reloading 0; DIV = 0 ticks every cycle.
REQ-018 SHALL clear the prescaler on any DIV write; new DIV applies from the next cycle.
REQ-019 SHALL increment pwm_cnt (PWM_BITS) on each tick, wrapping 2^PWM_BITS-1 -> 0.
REQ-020 SHALL write DUTY into a shadow register and set duty_pending; the shadow SHALL transfer to active duty on the tick that wraps pwm_cnt to 0, clearing duty_pending.
REQ-021 SHALL read DUTY as the shadow value.
REQ-022 SHALL compute per channel i: next_out[i] = DATA[i] & (MODE[i] ? (pwm_cnt < duty_active) : 1).
REQ-023 SHALL register out_port from next_out, giving one-cycle latency from any DATA/MODE/counter change.
REQ-024 SHALL hold a channel constantly low when duty_active = 0; duty_active = 2^PWM_BITS-1 yields high for all but one count per period.
REQ-025 SHALL, on DUTY write coinciding with the wrap tick, transfer the old shadow and leave the new value pending.
REQ-026 SHALL ignore writedata bits above each register's width.

Reset
REQ-027 SHALL on reset_n low asynchronously set DATA = RESET_DATA, MODE = 0, shadow and active duty = 0, duty_pending = 0, DIV = 0, prescaler = 0, pwm_cnt = 0, out_port = RESET_DATA.
REQ-028 SHALL release reset synchronously to clk in the surrounding system; the block adds no synchroniser.
REQ-029 SHALL abandon any pending DUTY update when reset asserts mid-period.

Structure
REQ-030 SHALL place register offsets (ADDR_DATA..ADDR_STATUS) and STATUS bit positions in shared package led_pio_pkg.
REQ-031 SHALL isolate prescaler, pwm_cnt, shadow/active duty in sub-module led_pwm_gen, outputting pwm_cnt, duty_active, duty_pending.
REQ-032 SHALL keep register decode, DATA/MODE storage and output register in the top module.

Verification
REQ-033 SHALL cover: reset, write DATA=0x15 -> out_port=0x15 one cycle later, read 0 returns 0x00000015.
REQ-034 SHALL cover: DATA=0x15, SET 0x0A -> DATA 0x1F; CLEAR 0x03 -> DATA 0x1C; reads of addr 1/2 return 0x1C.
REQ-035 SHALL cover: DIV=0, MODE=0x01, DATA=0x01, DUTY=64 -> after first wrap out_port[0] high exactly 64 of every 256 cycles, STATUS bit16 cleared at wrap.
REQ-036 SHALL cover: DIV=3 -> tick every 4 cycles, pwm_cnt increments once per 4 cycles; DIV rewrite mid-count restarts prescaler.
REQ-037 SHALL cover: DUTY=0 -> channel stays low; DUTY=255 -> low only when pwm_cnt=255; DUTY written on wrap cycle stays pending one full period.
REQ-038 SHALL cover: reset asserted mid-period with pending DUTY -> all state to reset values immediately, pending lost, out_port = RESET_DATA.
